// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, transmitter and their FIFOs.
package uart_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned AF_LEVEL   = 12;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-stream handshake between the UART receiver, the RX FIFO and its consumer.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_W = uart_pkg::DATA_W,
    parameter int unsigned DEPTH  = uart_pkg::FIFO_DEPTH
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              rd_en;
    logic              ovr_clr;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [CNT_W-1:0]  count;
    logic              overrun;
    logic              underrun;

    // The FIFO itself.
    modport slave (
        input  wr_data, wr_en, rd_en, ovr_clr,
        output rd_data, empty, full, almost_full, count, overrun, underrun
    );

    // Receiver/consumer side driving the FIFO.
    modport master (
        output wr_data, wr_en, rd_en, ovr_clr,
        input  rd_data, empty, full, almost_full, count, overrun, underrun
    );

endinterface

// File: rtl/uart_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read, contents never reset.
module uart_fifo_ram #(
    parameter int unsigned DATA_W = uart_pkg::DATA_W,
    parameter int unsigned DEPTH  = uart_pkg::FIFO_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: first-word fall-through, registered count, sticky overrun/underrun flags.
module uart_rx_fifo #(
    parameter int unsigned DATA_W   = uart_pkg::DATA_W,
    parameter int unsigned DEPTH    = uart_pkg::FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = uart_pkg::AF_LEVEL
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overrun_q, overrun_d;
    logic              underrun_q, underrun_d;
    logic              is_empty, is_full;
    logic              wr_accept, rd_accept, drop;
    logic [DATA_W-1:0] head_data;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));

    // A full FIFO still takes a write when the head is popped on the same edge.
    assign wr_accept = bus.wr_en && (!is_full || bus.rd_en);
    assign rd_accept = bus.rd_en && !is_empty;
    assign drop      = bus.wr_en && is_full && !bus.rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A fresh drop outranks a clear request in the same cycle.
        overrun_d = overrun_q;
        if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
        underrun_d = underrun_q | (bus.rd_en && is_empty);
    end

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    always_comb begin
        bus.rd_data     = head_data;
        bus.empty       = is_empty;
        bus.full        = is_full;
        bus.almost_full = (count_q >= CNT_W'(AF_LEVEL));
        bus.count       = count_q;
        bus.overrun     = overrun_q;
        bus.underrun    = underrun_q;
    end

endmodule
